pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage 64-bit pipeline. It drives the enables and flushes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves branches from EX/MEM-stage flags, inserts load-use bubbles, and sequences a req/ack handshake with a variable-latency data memory, including a timeout. State updates on the rising edge; the register-control outputs are combinational and settle before the falling edge at which the pipeline registers capture.

---
 rtl/pipeline_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves branches held in EX/MEM, inserts load-use bubbles and sequences the
// req/ack handshake with a variable-latency data memory, aborting on timeout.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   idex_MemRead, idex_rd            load in ID/EX and its destination
//   ifid_rs1, ifid_rs2               sources of the IF/ID instruction
//   exmem_Branch/Zero/Is_Greater     branch flags held in EX/MEM
//   exmem_funct                      {funct7[5], funct3} held in EX/MEM
//   exmem_MemRead/MemWrite           memory access held in EX/MEM
//   dmem_ack / dmem_req              data-memory handshake
//   pc_en, *_en, *_flush, pc_src     combinational pipeline-register controls
//   mem_fault                        sticky memory-timeout flag
//   stall_cycles, flush_events       saturating performance counters
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             exmem_Branch,
  input  logic             exmem_Zero,
  input  logic             exmem_Is_Greater,
  input  logic [3:0]       exmem_funct,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_src,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // Wait counter only has to hold values up to TIMEOUT-2 (see timeout below).
  localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_cnt_nx;

  logic branch_cond;
  logic taken;
  logic lu;
  logic acc;
  logic timeout;
  logic mem_stall;
  logic flush_inc;
  logic unused_funct7;

  // funct7[5] does not distinguish branch kinds.
  assign unused_funct7 = exmem_funct[3];

  // Branch resolution from EX/MEM flags.
  always_comb begin
    branch_cond = 1'b0;
    case (exmem_funct[2:0])
      3'b000:  branch_cond = exmem_Zero;
      3'b001:  branch_cond = !exmem_Zero;
      3'b100:  branch_cond = !exmem_Zero && !exmem_Is_Greater;
      3'b101:  branch_cond = exmem_Zero || exmem_Is_Greater;
      default: branch_cond = 1'b0;
    endcase
    taken = exmem_Branch && branch_cond;
  end

  // Load-use hazard between the load in ID/EX and the instruction in IF/ID.
  assign lu = idex_MemRead && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  assign acc = exmem_MemRead || exmem_MemWrite;

  // Memory FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  // Memory FSM next state and request. The IDLE request cycle is the first
  // wait cycle, so the TIMEOUT-th request cycle without an ack (WAIT with
  // wait_cnt at TIMEOUT-2, about to reach TIMEOUT-1) aborts.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    dmem_req    = 1'b0;
    timeout     = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          dmem_req = 1'b1;
          if (!dmem_ack) begin
            state_nx    = S_WAIT;
            wait_cnt_nx = '0;
          end
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_nx    = S_IDLE;
          wait_cnt_nx = '0;
        end else if (wait_cnt == WCNT_W'(TIMEOUT - 2)) begin
          timeout     = 1'b1;
          state_nx    = S_IDLE;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + WCNT_W'(1);
        end
      end
      default: begin
        state_nx    = S_IDLE;
        wait_cnt_nx = '0;
      end
    endcase
    if (reset) begin
      dmem_req = 1'b0;
      timeout  = 1'b0;
    end
  end

  assign mem_stall = acc && !dmem_ack && !timeout;

  // Pipeline-register controls, highest priority first.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_src      = 1'b0;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; MEM/WB keeps draining bubbles.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (timeout) begin
      // Aborted access becomes a bubble as it leaves EX/MEM.
      memwb_flush = 1'b1;
    end else if (taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign flush_inc = timeout || (taken && !mem_stall);

  // Sticky fault flag and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_fault    <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (timeout) begin
        mem_fault <= 1'b1;
      end
      if (!pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush_inc && (flush_events != '1)) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors for pipeline_ctrl (TIMEOUT=4, CNT_W=4),
// checked every cycle against a priority-table model plus literal spot checks.
module tb_pipeline_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = (1 << CW) - 1;

  localparam int M_RST   = 0;
  localparam int M_MEM   = 1;
  localparam int M_TMO   = 2;
  localparam int M_TAKEN = 3;
  localparam int M_LU    = 4;
  localparam int M_DEF   = 5;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic       mw;
    logic       ack;
    logic       br;
    logic       z;
    logic       gt;
    logic [3:0] fn;
    logic       idmr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          idex_MemRead;
  logic [4:0]    idex_rd;
  logic [4:0]    ifid_rs1;
  logic [4:0]    ifid_rs2;
  logic          exmem_Branch;
  logic          exmem_Zero;
  logic          exmem_Is_Greater;
  logic [3:0]    exmem_funct;
  logic          exmem_MemRead;
  logic          exmem_MemWrite;
  logic          dmem_ack;
  logic          dmem_req;
  logic          pc_en;
  logic          ifid_en;
  logic          idex_en;
  logic          exmem_en;
  logic          memwb_en;
  logic          ifid_flush;
  logic          idex_flush;
  logic          exmem_flush;
  logic          memwb_flush;
  logic          pc_src;
  logic          mem_fault;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_events;

  int n_vec = 0;
  int n_err = 0;

  // Model state: request cycles already spent on the pending access.
  int   m_reqs  = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  logic m_fault = 1'b0;

  pipeline_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .idex_MemRead     (idex_MemRead),
    .idex_rd          (idex_rd),
    .ifid_rs1         (ifid_rs1),
    .ifid_rs2         (ifid_rs2),
    .exmem_Branch     (exmem_Branch),
    .exmem_Zero       (exmem_Zero),
    .exmem_Is_Greater (exmem_Is_Greater),
    .exmem_funct      (exmem_funct),
    .exmem_MemRead    (exmem_MemRead),
    .exmem_MemWrite   (exmem_MemWrite),
    .dmem_ack         (dmem_ack),
    .dmem_req         (dmem_req),
    .pc_en            (pc_en),
    .ifid_en          (ifid_en),
    .idex_en          (idex_en),
    .exmem_en         (exmem_en),
    .memwb_en         (memwb_en),
    .ifid_flush       (ifid_flush),
    .idex_flush       (idex_flush),
    .exmem_flush      (exmem_flush),
    .memwb_flush      (memwb_flush),
    .pc_src           (pc_src),
    .mem_fault        (mem_fault),
    .stall_cycles     (stall_cycles),
    .flush_events     (flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid/idex/exmem/memwb_flush, pc_src}
  function automatic logic [9:0] ctrl_of(input int mode);
    case (mode)
      M_RST:   return 10'b01111_1111_0;
      M_MEM:   return 10'b00001_0001_0;
      M_TMO:   return 10'b11111_0001_0;
      M_TAKEN: return 10'b11111_1110_1;
      M_LU:    return 10'b00111_0100_0;
      default: return 10'b11111_0000_0;
    endcase
  endfunction

  // Model and per-cycle compare on the falling edge.
  always @(negedge clk) begin : model
    logic       acc;
    logic       req;
    logic       tmo;
    logic       stl;
    logic       tk;
    logic       luh;
    logic [9:0] e_ctrl;
    int         k;
    int         mode;
    acc = exmem_MemRead | exmem_MemWrite;
    req = !reset && (acc || (m_reqs > 0));
    k   = m_reqs + 1;
    tmo = req && !dmem_ack && (k == int'(TO));
    stl = !reset && acc && !dmem_ack && !tmo;
    case (exmem_funct[2:0])
      3'b000:  tk = exmem_Zero;
      3'b001:  tk = !exmem_Zero;
      3'b100:  tk = !exmem_Zero && !exmem_Is_Greater;
      3'b101:  tk = exmem_Zero || exmem_Is_Greater;
      default: tk = 1'b0;
    endcase
    tk  = tk && exmem_Branch;
    luh = idex_MemRead && (idex_rd != 5'd0) &&
          ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    if (reset)    mode = M_RST;
    else if (stl) mode = M_MEM;
    else if (tmo) mode = M_TMO;
    else if (tk)  mode = M_TAKEN;
    else if (luh) mode = M_LU;
    else          mode = M_DEF;
    e_ctrl = ctrl_of(mode);
    chk("ctrl", 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_src}),
        16'(e_ctrl));
    chk("dmem_req", 16'(dmem_req), 16'(req));
    chk("mem_fault", 16'(mem_fault), 16'(m_fault));
    chk("stall_cycles", 16'(stall_cycles), 16'(m_stall));
    chk("flush_events", 16'(flush_events), 16'(m_flush));
    if (reset) begin
      m_reqs  = 0;
      m_stall = 0;
      m_flush = 0;
      m_fault = 1'b0;
    end else begin
      m_reqs = (req && !dmem_ack && !tmo) ? k : 0;
      if (tmo) m_fault = 1'b1;
      if (!e_ctrl[9] && m_stall < SAT) m_stall++;
      if ((mode == M_TMO || mode == M_TAKEN) && m_flush < SAT) m_flush++;
    end
  end

  task automatic put(input vec_t v);
    reset            = v.rst;
    exmem_MemRead    = v.mr;
    exmem_MemWrite   = v.mw;
    dmem_ack         = v.ack;
    exmem_Branch     = v.br;
    exmem_Zero       = v.z;
    exmem_Is_Greater = v.gt;
    exmem_funct      = v.fn;
    idex_MemRead     = v.idmr;
    idex_rd          = v.rd;
    ifid_rs1         = v.rs1;
    ifid_rs2         = v.rs2;
  endtask

  // Apply a vector for one cycle; returns just after the falling edge.
  task automatic cyc(input vec_t v);
    @(posedge clk);
    #1;
    put(v);
    @(negedge clk);
    #1;
  endtask

  function automatic vec_t br_vec(input logic [3:0] fn, input logic z, input logic gt);
    vec_t v;
    v    = '0;
    v.br = 1'b1;
    v.fn = fn;
    v.z  = z;
    v.gt = gt;
    return v;
  endfunction

  initial begin : stim
    vec_t nop;
    vec_t v;
    nop = '0;
    v = nop;
    v.rst = 1'b1;
    put(v);

    // Reset
    cyc(v);
    cyc(v);
    chk("rst_pc_en", 16'(pc_en), 16'(0));
    chk("rst_flush", 16'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 16'(4'hF));
    chk("rst_req", 16'(dmem_req), 16'(0));
    cyc(nop);
    chk("post_rst_cnt", 16'({stall_cycles, flush_events}), 16'(0));
    chk("post_rst_fault", 16'(mem_fault), 16'(0));
    chk("idle_pc_en", 16'(pc_en), 16'(1));

    // Load-use on rs2, then on rs1, and a load to x0
    v = nop; v.idmr = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5;
    cyc(v);
    chk("lu_en", 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 16'(5'b00111));
    chk("lu_flush", 16'(idex_flush), 16'(1));
    cyc(nop);
    chk("lu_stall", 16'(stall_cycles), 16'(1));
    chk("lu_clear", 16'(pc_en), 16'(1));
    v = nop; v.idmr = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7;
    cyc(v);
    chk("lu_rs1", 16'(pc_en), 16'(0));
    v = nop; v.idmr = 1'b1;
    cyc(v);
    chk("lu_x0", 16'(pc_en), 16'(1));

    // Taken bne with a simultaneous load-use
    v = br_vec(4'b0001, 1'b0, 1'b0); v.idmr = 1'b1; v.rd = 5'd5; v.rs1 = 5'd5;
    cyc(v);
    chk("bne_src", 16'(pc_src), 16'(1));
    chk("bne_flush", 16'({ifid_flush, idex_flush, exmem_flush, memwb_flush}), 16'(4'b1110));
    chk("bne_pc_en", 16'(pc_en), 16'(1));
    cyc(nop);
    chk("bne_events", 16'(flush_events), 16'(1));
    chk("bne_stalls", 16'(stall_cycles), 16'(2));

    // Branch condition table
    cyc(br_vec(4'b0101, 1'b0, 1'b0));
    chk("bge_nt_src", 16'(pc_src), 16'(0));
    chk("bge_nt_flush", 16'({ifid_flush, idex_flush, exmem_flush}), 16'(0));
    cyc(br_vec(4'b0101, 1'b0, 1'b1));
    cyc(br_vec(4'b0000, 1'b1, 1'b0));
    cyc(br_vec(4'b0100, 1'b0, 1'b0));
    cyc(br_vec(4'b0100, 1'b0, 1'b1));
    cyc(br_vec(4'b0100, 1'b1, 1'b0));
    cyc(br_vec(4'b0010, 1'b1, 1'b0));
    v = br_vec(4'b0000, 1'b1, 1'b0); v.br = 1'b0;
    cyc(v);
    chk("nobranch_src", 16'(pc_src), 16'(0));
    cyc(br_vec(4'b1000, 1'b1, 1'b0));
    cyc(br_vec(4'b0001, 1'b1, 1'b0));
    cyc(nop);
    chk("br_events", 16'(flush_events), 16'(5));

    // Latency-3 read; the ack coincides with the last allowed cycle
    v = nop; v.mr = 1'b1;
    cyc(v);
    chk("mem_req", 16'(dmem_req), 16'(1));
    chk("mem_en", 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 16'(5'b00001));
    chk("mem_wbflush", 16'(memwb_flush), 16'(1));
    cyc(v);
    cyc(v);
    v.ack = 1'b1;
    cyc(v);
    chk("mem_ack_pc_en", 16'(pc_en), 16'(1));
    chk("mem_ack_wbflush", 16'(memwb_flush), 16'(0));
    cyc(nop);
    chk("mem_req_drop", 16'(dmem_req), 16'(0));
    chk("mem_stalls", 16'(stall_cycles), 16'(5));
    chk("mem_tie_fault", 16'(mem_fault), 16'(0));

    // Latency-1 write, zero-wait read, stray ack
    v = nop; v.mw = 1'b1;
    cyc(v);
    v.ack = 1'b1;
    cyc(v);
    v = nop; v.mr = 1'b1; v.ack = 1'b1;
    cyc(v);
    chk("zw_pc_en", 16'(pc_en), 16'(1));
    chk("zw_req", 16'(dmem_req), 16'(1));
    v = nop; v.ack = 1'b1;
    cyc(v);
    chk("stray_ack_req", 16'(dmem_req), 16'(0));
    chk("zw_stalls", 16'(stall_cycles), 16'(6));

    // Timeout
    v = nop; v.mr = 1'b1;
    repeat (3) cyc(v);
    chk("tmo_pre_fault", 16'(mem_fault), 16'(0));
    cyc(v);
    chk("tmo_en", 16'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 16'(5'b11111));
    chk("tmo_flush", 16'({exmem_flush, memwb_flush}), 16'(2'b01));
    cyc(nop);
    chk("tmo_fault", 16'(mem_fault), 16'(1));
    chk("tmo_events", 16'(flush_events), 16'(6));
    chk("tmo_stalls", 16'(stall_cycles), 16'(9));
    repeat (3) cyc(nop);
    chk("tmo_sticky", 16'(mem_fault), 16'(1));

    // Counter saturation
    v = nop; v.idmr = 1'b1; v.rd = 5'd3; v.rs1 = 5'd3;
    repeat (6) cyc(v);
    cyc(nop);
    chk("stall_full", 16'(stall_cycles), 16'(15));
    repeat (4) cyc(v);
    cyc(nop);
    chk("stall_sat", 16'(stall_cycles), 16'(15));
    repeat (12) cyc(br_vec(4'b0000, 1'b1, 1'b0));
    cyc(nop);
    chk("flush_sat", 16'(flush_events), 16'(15));

    // Reset during WAIT
    v = nop; v.mr = 1'b1;
    cyc(v);
    cyc(v);
    chk("wait_req", 16'(dmem_req), 16'(1));
    v.rst = 1'b1;
    cyc(v);
    chk("rstwait_req", 16'(dmem_req), 16'(0));
    chk("rstwait_pc_en", 16'(pc_en), 16'(0));
    cyc(nop);
    chk("rstwait_fault", 16'(mem_fault), 16'(0));
    chk("rstwait_cnt", 16'({stall_cycles, flush_events}), 16'(0));
    chk("rstwait_idle", 16'(dmem_req), 16'(0));
    v = nop; v.mr = 1'b1;
    repeat (2) cyc(v);
    v.ack = 1'b1;
    cyc(v);
    cyc(nop);
    chk("fresh_stalls", 16'(stall_cycles), 16'(2));
    chk("fresh_fault", 16'(mem_fault), 16'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
